uart_tx_monitor: RTL

- Bench-side UART receiver that consumes the SoC's standard UART transmit line (io_uartStd_txd) and turns the serial stream into bytes for the testbench.
- Drives the SoC's clear-to-send input for flow control.
- Buffers decoded bytes in a small FIFO, exposed through a valid/ready interface.
- Flags framing and overrun errors so benches can check firmware console output cycle-accurately.

---
 rtl/uart_tx_monitor_pkg.sv | 24 ++
 rtl/uart_tx_monitor_byte_fifo.sv | 63 ++++++
 rtl/uart_tx_monitor.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_monitor_pkg.sv
// rtl/uart_tx_monitor_pkg.sv - shared types, constants and baud helpers for the UART monitor
package uart_tx_monitor_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_e;

   // Whole clock cycles per serial bit; the remainder is simply dropped.
   function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
      return clk_freq_hz / baud;
   endfunction

   // Width that can hold 0 .. clks_per_bit-1 (never less than one bit).
   function automatic int cnt_width(input int clk_freq_hz, input int baud);
      return $clog2(clks_per_bit(clk_freq_hz, baud) + 1);
   endfunction

endpackage

// File: rtl/uart_tx_monitor_byte_fifo.sv
// rtl/uart_tx_monitor_byte_fifo.sv - first-word-fall-through synchronous FIFO for decoded bytes
module byte_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             wr_en, rd_en;

   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   // A pop frees the slot a same-cycle push needs, so full does not block it.
   assign rd_en   = pop_i && !empty_o;
   assign wr_en   = push_i && (!full_o || rd_en);
   // Head byte is presented combinationally; zero while nothing is stored.
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   // Pointer and level bookkeeping for the accepted push/pop of this cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_en && !rd_en) level_d = level_q + (AW+1)'(1);
      else if (rd_en && !wr_en) level_d = level_q - (AW+1)'(1);
   end

   // Storage array; contents need no reset because level gates visibility.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
   end

   // Pointer and level registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/uart_tx_monitor.sv
// rtl/uart_tx_monitor.sv - bench-side UART receiver with byte FIFO, CTS and error flags
module uart_tx_monitor
   import uart_tx_monitor_pkg::*;
#(
   parameter int CLK_FREQ_HZ   = 100_000_000,
   parameter int BAUD          = 115_200,
   parameter int FIFO_DEPTH    = 16,
   parameter int CTS_THRESHOLD = 12
) (
   input  logic        io_clock,
   input  logic        io_sysReset_n,
   input  logic        io_rxd,
   output logic        io_cts,
   output logic [7:0]  io_data,
   output logic        io_valid,
   input  logic        io_ready,
   output logic        io_frameError,
   output logic        io_overrun,
   input  logic        io_errorClear,
   output logic [31:0] io_byteCount
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
   localparam int CW           = cnt_width(CLK_FREQ_HZ, BAUD);
   localparam int LW           = $clog2(FIFO_DEPTH) + 1;
   localparam int BW           = $clog2(DATA_BITS);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic                 rst_meta_q, rst_sync_q, rst_n;
   logic                 rxd_meta_q, rxd_s_q;
   rx_state_e            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 push, frame_set;
   logic                 fifo_full, fifo_empty, pop, push_ok, overrun_set;
   logic [LW-1:0]        level;
   logic                 frame_q, frame_d, overrun_q, overrun_d, cts_q, cts_d;
   logic [31:0]          count_q, count_d;

   // Reset asserts immediately but is released in step with the clock.
   always_ff @(posedge io_clock or negedge io_sysReset_n) begin
      if (!io_sysReset_n) {rst_meta_q, rst_sync_q} <= 2'b00;
      else                {rst_meta_q, rst_sync_q} <= {1'b1, rst_meta_q};
   end
   assign rst_n = rst_sync_q;

   // Two-flop synchroniser on the serial line; idles high out of reset.
   always_ff @(posedge io_clock or negedge rst_n) begin
      if (!rst_n) {rxd_meta_q, rxd_s_q} <= 2'b11;
      else        {rxd_meta_q, rxd_s_q} <= {io_rxd, rxd_meta_q};
   end

   // Receive FSM: mid-bit sampling, LSB first, stop-bit validation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      push      = 1'b0;
      frame_set = 1'b0;
      unique case (state_q)
         IDLE: if (!rxd_s_q) begin
            state_d = START;
            cnt_d   = '0;
         end
         START: if (cnt_q == HALF_LAST) begin
            cnt_d = '0;
            bit_d = '0;
            state_d = rxd_s_q ? IDLE : DATA;
         end else cnt_d = cnt_q + CW'(1);
         DATA: if (cnt_q == BIT_LAST) begin
            cnt_d   = '0;
            shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == BW'(DATA_BITS - 1)) state_d = STOP;
            else bit_d = bit_q + BW'(1);
         end else cnt_d = cnt_q + CW'(1);
         STOP: if (cnt_q == BIT_LAST) begin
            cnt_d = '0;
            if (rxd_s_q) begin
               push    = 1'b1;
               state_d = IDLE;
            end else begin
               frame_set = 1'b1;
               state_d   = BREAK;
            end
         end else cnt_d = cnt_q + CW'(1);
         BREAK: if (rxd_s_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Receive FSM registers.
   always_ff @(posedge io_clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   assign pop         = !fifo_empty && io_ready;
   assign push_ok     = push && (!fifo_full || pop);
   assign overrun_set = push && fifo_full && !pop;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk_i   (io_clock),
      .rst_ni  (rst_n),
      .push_i  (push),
      .wdata_i (shift_q),
      .pop_i   (pop),
      .rdata_o (io_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level)
   );

   // Sticky flags (a new error beats a clear), byte counter and CTS level.
   always_comb begin
      frame_d   = frame_set   | (frame_q   & ~io_errorClear);
      overrun_d = overrun_set | (overrun_q & ~io_errorClear);
      count_d   = count_q + {31'd0, push_ok};
      cts_d     = (level >= LW'(CTS_THRESHOLD));
   end

   // Status registers.
   always_ff @(posedge io_clock or negedge rst_n) begin
      if (!rst_n) begin
         frame_q   <= 1'b0;
         overrun_q <= 1'b0;
         count_q   <= '0;
         cts_q     <= 1'b0;
      end else begin
         frame_q   <= frame_d;
         overrun_q <= overrun_d;
         count_q   <= count_d;
         cts_q     <= cts_d;
      end
   end

   assign io_valid      = !fifo_empty;
   assign io_cts        = cts_q;
   assign io_frameError = frame_q;
   assign io_overrun    = overrun_q;
   assign io_byteCount  = count_q;

endmodule
